pipeline_fetch: RTL and testbench

- Instruction fetch stage directly upstream of pipeline_decode; owns the PC and issues in-order requests to instruction memory.
- Buffers returned words in a small FIFO and presents one instruction per cycle on inst_out, which feeds decode's inst_in.
- Bubbles are emitted as 32'b0, which decode already treats as NOP.
- Handles downstream stall and branch/jump redirect, discarding wrong-path responses that are still in flight.

---
 rtl/pipeline_fetch.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction fetch stage feeding pipeline_decode.
// Owns the PC, issues in-order requests to instruction memory, buffers
// returned words in a small FIFO and presents one instruction per cycle.
// Wrong-path responses still in flight after a redirect are counted and
// dropped as they return.
module pipeline_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_CNT = (CW+1)'(FIFO_DEPTH);

  // Architectural state
  logic [31:0]   pc_reg, pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [AW-1:0] fifo_wr_ptr_reg, fifo_wr_ptr_next;
  logic [AW-1:0] fifo_rd_ptr_reg, fifo_rd_ptr_next;
  logic [AW-1:0] tag_wr_ptr_reg, tag_wr_ptr_next;
  logic [AW-1:0] tag_rd_ptr_reg, tag_rd_ptr_next;
  logic [31:0]   inst_out_reg, inst_out_next;
  logic [31:0]   pc_out_reg, pc_out_next;
  logic          inst_valid_reg, inst_valid_next;

  // Storage: instruction buffer (word + PC) and PC tags of in-flight requests
  logic [31:0] fifo_inst_mem [FIFO_DEPTH];
  logic [31:0] fifo_pc_mem   [FIFO_DEPTH];
  logic [31:0] tag_pc_mem    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_we;
  logic [FIFO_DEPTH-1:0] tag_we;

  logic [CW:0] in_use;
  logic        grant;
  logic        drop;
  logic        push;
  logic        pop;
  logic [31:0] tag_head;
  logic        unused_redirect_bits;

  // Fetch addresses are word aligned; the low redirect bits are ignored.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Credit: in-flight plus buffered words never exceed the buffer size, so
  // every response is guaranteed a slot.
  assign in_use    = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};
  assign imem_req  = rst_n && !redirect_valid && (in_use < DEPTH_CNT);
  assign imem_addr = pc_reg;

  assign grant    = imem_req && imem_gnt;
  assign drop     = imem_rvalid && (discard_reg != '0);
  assign push     = imem_rvalid && !drop && !redirect_valid;
  assign pop      = !redirect_valid && !stall && (fifo_count_reg != '0);
  assign tag_head = tag_pc_mem[tag_rd_ptr_reg];

  assign inst_out   = inst_out_reg;
  assign pc_out     = pc_out_reg;
  assign inst_valid = inst_valid_reg;

  // Per-entry write enables for the word buffer and the tag buffer.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
      assign fifo_we[gi] = push  && (fifo_wr_ptr_reg == AW'(gi));
      assign tag_we[gi]  = grant && (tag_wr_ptr_reg  == AW'(gi));
    end
  endgenerate

  // Next-state for PC, credit counters and buffer pointers.
  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg + CW'(grant) - CW'(imem_rvalid);
    discard_next     = discard_reg;
    fifo_count_next  = fifo_count_reg + CW'(push) - CW'(pop);
    fifo_wr_ptr_next = fifo_wr_ptr_reg;
    fifo_rd_ptr_next = fifo_rd_ptr_reg;
    tag_wr_ptr_next  = tag_wr_ptr_reg;
    tag_rd_ptr_next  = tag_rd_ptr_reg;

    if (grant) begin
      pc_next         = pc_reg + 32'd4;
      tag_wr_ptr_next = tag_wr_ptr_reg + AW'(1);
    end
    // Tags track every request actually sent, so they are never flushed.
    if (imem_rvalid) begin
      tag_rd_ptr_next = tag_rd_ptr_reg + AW'(1);
    end
    if (push) begin
      fifo_wr_ptr_next = fifo_wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      fifo_rd_ptr_next = fifo_rd_ptr_reg + AW'(1);
    end
    if (drop) begin
      discard_next = discard_reg - CW'(1);
    end

    // Redirect: everything still in flight after this cycle is wrong-path.
    if (redirect_valid) begin
      pc_next          = {redirect_pc[31:2], 2'b00};
      discard_next     = outstanding_reg - CW'(imem_rvalid);
      fifo_count_next  = '0;
      fifo_wr_ptr_next = '0;
      fifo_rd_ptr_next = '0;
    end
  end

  // Next-state for the decode-facing output register.
  always_comb begin
    inst_out_next   = inst_out_reg;
    pc_out_next     = pc_out_reg;
    inst_valid_next = inst_valid_reg;
    if (redirect_valid) begin
      inst_out_next   = 32'b0;
      inst_valid_next = 1'b0;
    end else if (stall) begin
      inst_out_next   = inst_out_reg;
    end else if (pop) begin
      inst_out_next   = fifo_inst_mem[fifo_rd_ptr_reg];
      pc_out_next     = fifo_pc_mem[fifo_rd_ptr_reg];
      inst_valid_next = 1'b1;
    end else begin
      inst_out_next   = 32'b0;
      inst_valid_next = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fifo_count_reg  <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      inst_out_reg    <= 32'b0;
      pc_out_reg      <= 32'b0;
      inst_valid_reg  <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      fifo_count_reg  <= fifo_count_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_next;
      fifo_rd_ptr_reg <= fifo_rd_ptr_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      inst_out_reg    <= inst_out_next;
      pc_out_reg      <= pc_out_next;
      inst_valid_reg  <= inst_valid_next;
    end
  end

  // Buffer storage; contents are only read once written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_we[i]) begin
        fifo_inst_mem[i] <= imem_rdata;
        fifo_pc_mem[i]   <= tag_head;
      end
      if (tag_we[i]) begin
        tag_pc_mem[i] <= pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: directed tests for pipeline_fetch with a small
// in-order instruction memory model of programmable latency.
module tb_pipeline_fetch;

  localparam logic [31:0] RESET_PC   = 32'hBFC00000;
  localparam int          FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'b0;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;

  int n_cmp = 0;
  int n_err = 0;
  int mem_lat = 1;
  int edge_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t mem_q[$];

  pipeline_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    return RESET_PC + 32'(i * 4);
  endfunction

  // Memory model: records grants at the clock edge, answers in order after mem_lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'b0;
    end else begin
      edge_cnt = edge_cnt + 1;
      if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) mem_q.push_back('{addr: imem_addr, due: edge_cnt + mem_lat});
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= edge_cnt + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'b0;
      end
    end
  end

  // One line per instruction handed to decode.
  always @(negedge clk) begin
    if (rst_n && inst_valid && !stall)
      $display("fetch: pc=%08h inst=%08h", pc_out, inst_out);
  end

  // Advance to the next falling edge and check the credit/counter invariants.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      n_cmp++;
      if ((32'(dut.outstanding_reg) + 32'(dut.fifo_count_reg) > FIFO_DEPTH) ||
          (dut.discard_reg > dut.outstanding_reg)) begin
        n_err++;
        $display("FAIL invariant: outstanding=%0d fifo_count=%0d discard=%0d limit=%0d",
                 dut.outstanding_reg, dut.fifo_count_reg, dut.discard_reg, FIFO_DEPTH);
      end
    end
  endtask

  // Hold reset for two cycles, then release on a falling edge.
  task automatic do_reset(input int lat, input logic gnt);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'b0;
    mem_lat = lat; imem_gnt = gnt;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'b0;
    imem_gnt = 1'b1; mem_lat = 1;
    tick(); tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %08h want %08h", imem_addr, RESET_PC); end
    n_cmp++; if (inst_out !== 32'b0) begin n_err++; $display("FAIL reset_inst: got %08h want 0", inst_out); end
    n_cmp++; if (pc_out !== 32'b0) begin n_err++; $display("FAIL reset_pc_out: got %08h want 0", pc_out); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_release_req: got %0b want 1", imem_req); end
  endtask

  // 1-cycle memory, grant always high; leaves the stream running at negedge 8.
  task automatic test_stream();
    do_reset(1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++; if (imem_addr !== pc_at(k)) begin n_err++; $display("FAIL stream_addr[%0d]: got %08h want %08h", k, imem_addr, pc_at(k)); end
      if (k < 3) begin
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency[%0d]: valid=%0b want 0", k, inst_valid); end
      end else begin
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b want 1", k, inst_valid); end
        n_cmp++; if (pc_out !== pc_at(k-3)) begin n_err++; $display("FAIL stream_pc[%0d]: got %08h want %08h", k, pc_out, pc_at(k-3)); end
        n_cmp++; if (inst_out !== mem_word(pc_at(k-3))) begin n_err++; $display("FAIL stream_inst[%0d]: got %08h want %08h", k, inst_out, mem_word(pc_at(k-3))); end
      end
    end
  endtask

  // Continues from test_stream: output holds pc_at(5), request drops at full credit.
  task automatic test_stall();
    stall = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      n_cmp++; if (pc_out !== pc_at(5)) begin n_err++; $display("FAIL stall_pc[%0d]: got %08h want %08h", j, pc_out, pc_at(5)); end
      n_cmp++; if (inst_out !== mem_word(pc_at(5)) || inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d]: inst=%08h valid=%0b want %08h 1", j, inst_out, inst_valid, mem_word(pc_at(5))); end
      n_cmp++; if (imem_req !== (j == 1)) begin n_err++; $display("FAIL stall_req[%0d]: got %0b want %0b", j, imem_req, (j == 1)); end
      n_cmp++; if (imem_addr !== pc_at(j == 1 ? 9 : 10)) begin n_err++; $display("FAIL stall_addr[%0d]: got %08h want %08h", j, imem_addr, pc_at(j == 1 ? 9 : 10)); end
    end
    stall = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b1 || pc_out !== pc_at(6+j)) begin n_err++; $display("FAIL stall_resume[%0d]: valid=%0b pc=%08h want 1 %08h", j, inst_valid, pc_out, pc_at(6+j)); end
    end
  endtask

  // 4-cycle memory, three requests in flight when the redirect arrives.
  task automatic test_redirect();
    do_reset(4, 1'b1);
    tick(); tick(); tick();
    n_cmp++; if (dut.outstanding_reg !== 3'd3) begin n_err++; $display("FAIL redir_inflight: got %0d want 3", dut.outstanding_reg); end
    redirect_valid = 1'b1; redirect_pc = 32'h00400010;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %0b want 0", imem_req); end
    tick();
    n_cmp++; if (imem_addr !== 32'h00400010) begin n_err++; $display("FAIL redir_addr: got %08h want 00400010", imem_addr); end
    n_cmp++; if (dut.discard_reg !== 3'd3) begin n_err++; $display("FAIL redir_discard: got %0d want 3", dut.discard_reg); end
    redirect_valid = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 32'b0) begin n_err++; $display("FAIL redir_gap[%0d]: valid=%0b inst=%08h want 0 0", k, inst_valid, inst_out); end
    end
    tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== 32'h00400010) begin n_err++; $display("FAIL redir_first: valid=%0b pc=%08h want 1 00400010", inst_valid, pc_out); end
    n_cmp++; if (inst_out !== mem_word(32'h00400010)) begin n_err++; $display("FAIL redir_first_inst: got %08h want %08h", inst_out, mem_word(32'h00400010)); end
  endtask

  task automatic test_misaligned();
    do_reset(1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h00400013;
    tick();
    n_cmp++; if (imem_addr !== 32'h00400010) begin n_err++; $display("FAIL misalign_addr: got %08h want 00400010", imem_addr); end
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== 32'h00400010) begin n_err++; $display("FAIL misalign_first: valid=%0b pc=%08h want 1 00400010", inst_valid, pc_out); end
  endtask

  // 2-cycle memory: redirect lands together with stall and a live response.
  task automatic test_redirect_stall_rvalid();
    do_reset(2, 1'b1);
    tick(); tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== pc_at(0)) begin n_err++; $display("FAIL rsr_pre: valid=%0b pc=%08h want 1 %08h", inst_valid, pc_out, pc_at(0)); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00001000;
    tick();
    n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 32'b0) begin n_err++; $display("FAIL rsr_clear: valid=%0b inst=%08h want 0 0", inst_valid, inst_out); end
    n_cmp++; if (pc_out !== pc_at(0)) begin n_err++; $display("FAIL rsr_pc_hold: got %08h want %08h", pc_out, pc_at(0)); end
    n_cmp++; if (dut.discard_reg !== 3'd1) begin n_err++; $display("FAIL rsr_discard: got %0d want 1", dut.discard_reg); end
    n_cmp++; if (dut.fifo_count_reg !== 3'd0) begin n_err++; $display("FAIL rsr_flush: got %0d want 0", dut.fifo_count_reg); end
    n_cmp++; if (imem_addr !== 32'h00001000) begin n_err++; $display("FAIL rsr_addr: got %08h want 00001000", imem_addr); end
    stall = 1'b0; redirect_valid = 1'b0;
    for (int k = 6; k <= 8; k++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rsr_gap[%0d]: valid=%0b want 0", k, inst_valid); end
    end
    tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== 32'h00001000 || inst_out !== mem_word(32'h00001000)) begin n_err++; $display("FAIL rsr_first: valid=%0b pc=%08h inst=%08h want 1 00001000 %08h", inst_valid, pc_out, inst_out, mem_word(32'h00001000)); end
  endtask

  task automatic test_gnt_low();
    do_reset(1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 32'b0) begin n_err++; $display("FAIL gnt_bubble[%0d]: valid=%0b inst=%08h want 0 0", k, inst_valid, inst_out); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL gnt_addr[%0d]: req=%0b addr=%08h want 1 %08h", k, imem_req, imem_addr, RESET_PC); end
    end
    imem_gnt = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== RESET_PC) begin n_err++; $display("FAIL gnt_first: valid=%0b pc=%08h want 1 %08h", inst_valid, pc_out, RESET_PC); end
  endtask

  // Asynchronous reset with two requests in flight, then a clean restart.
  task automatic test_async_reset();
    do_reset(2, 1'b1);
    tick(); tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || dut.outstanding_reg !== 3'd2) begin n_err++; $display("FAIL areset_pre: valid=%0b outstanding=%0d want 1 2", inst_valid, dut.outstanding_reg); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== RESET_PC || imem_req !== 1'b0) begin n_err++; $display("FAIL areset_pc: addr=%08h req=%0b want %08h 0", imem_addr, imem_req, RESET_PC); end
    n_cmp++; if (inst_out !== 32'b0 || pc_out !== 32'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL areset_out: inst=%08h pc=%08h valid=%0b want 0 0 0", inst_out, pc_out, inst_valid); end
    n_cmp++; if (dut.outstanding_reg !== 3'd0) begin n_err++; $display("FAIL areset_outstanding: got %0d want 0", dut.outstanding_reg); end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || pc_out !== RESET_PC || inst_out !== mem_word(RESET_PC)) begin n_err++; $display("FAIL areset_restart: valid=%0b pc=%08h inst=%08h want 1 %08h %08h", inst_valid, pc_out, inst_out, RESET_PC, mem_word(RESET_PC)); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'b0; imem_gnt = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_redirect_stall_rvalid();
    test_gnt_low();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
